imem_loader: RTL and testbench

- Upstream feeder for the Hack instruction memory.
- Takes a byte stream from a serial receiver and frames it into 16-bit instructions.
- Writes each instruction into a writable instruction RAM that the CPU fetches from.
- Holds the CPU in reset while loading, checks a trailer checksum, and releases the CPU only after a clean load.

---
 rtl/hack_pkg.sv | 27 ++
 rtl/loader_timeout.sv | 31 +++
 rtl/imem_loader.sv | 191 +++++++++++++++++++
 tb/tb_imem_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack instruction-memory loader.
package hack_pkg;

  localparam int unsigned HACK_ADDR_W = 15;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StDataHi,
    StDataLo,
    StCheck,
    StDone,
    StError
  } loader_state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // States in which the loader takes bytes from the receiver (and the idle timer runs).
  function automatic logic state_ready(input loader_state_t s);
    return s inside {StLenHi, StLenLo, StDataHi, StDataLo, StCheck};
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle counter: o_expired flags the cycle that completes TIMEOUT idle cycles.
module loader_timeout #(
  parameter int unsigned TIMEOUT = 1000000,
  parameter int unsigned TO_W    = 20
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [TO_W-1:0] LastIdle = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] r_count;

  // Count enabled idle cycles; clear takes priority.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  // The edge ending this cycle is the TIMEOUT-th idle edge since the last clear.
  assign o_expired = i_enable && (r_count == LastIdle);

endmodule

// File: rtl/imem_loader.sv
// Frames a byte stream into 16-bit words, writes them to instruction RAM, verifies the
// trailer XOR and only then releases the CPU from reset.
module imem_loader
  import hack_pkg::*;
#(
  parameter int unsigned ADDR_W  = HACK_ADDR_W,
  parameter int unsigned DEPTH   = 4096,
  parameter int unsigned TIMEOUT = 1000000,
  parameter int unsigned TO_W    = 20
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [15:0]       o_imem_wdata,
  output logic              o_cpu_reset,
  output logic              o_done,
  output logic [1:0]        o_error,
  output logic [ADDR_W:0]   o_word_count
);

  localparam logic [ADDR_W:0] WcOne = {{ADDR_W{1'b0}}, 1'b1};

  loader_state_t     r_state, w_state_d;
  logic              r_rx_ready;
  logic              r_imem_we, w_imem_we_d;
  logic [ADDR_W-1:0] r_imem_addr, w_imem_addr_d;
  logic [15:0]       r_imem_wdata, w_imem_wdata_d;
  logic              r_cpu_reset, w_cpu_reset_d;
  logic              r_done, w_done_d;
  logic [1:0]        r_error, w_error_d;
  logic [ADDR_W:0]   r_word_count, w_word_count_d;
  logic [7:0]        r_len_hi, w_len_hi_d;
  logic [15:0]       r_len, w_len_d;
  logic [7:0]        r_data_hi, w_data_hi_d;
  logic [7:0]        r_xor, w_xor_d;

  logic              w_accept;
  logic              w_expired;
  logic              w_to_clear;
  logic [15:0]       w_len_rx;
  logic [ADDR_W:0]   w_wc_inc;

  assign w_accept = i_rx_valid && r_rx_ready;
  assign w_len_rx = {r_len_hi, i_rx_data};
  assign w_wc_inc = r_word_count + WcOne;
  // Restart the idle timer on every byte and on each fresh load.
  assign w_to_clear = w_accept || ((w_state_d == StLenHi) && (r_state != StLenHi));

  loader_timeout #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (w_to_clear),
    .i_enable  (state_ready(r_state)),
    .o_expired (w_expired)
  );

  // Next-state and next-output decode.
  always_comb begin
    w_state_d      = r_state;
    w_imem_we_d    = 1'b0;
    w_imem_addr_d  = r_imem_addr;
    w_imem_wdata_d = r_imem_wdata;
    w_cpu_reset_d  = r_cpu_reset;
    w_done_d       = r_done;
    w_error_d      = r_error;
    w_word_count_d = r_word_count;
    w_len_hi_d     = r_len_hi;
    w_len_d        = r_len;
    w_data_hi_d    = r_data_hi;
    w_xor_d        = r_xor;

    unique case (r_state)
      StIdle, StDone, StError: begin
        if (i_start) begin
          w_state_d      = StLenHi;
          w_error_d      = ERR_NONE;
          w_done_d       = 1'b0;
          w_word_count_d = '0;
          w_xor_d        = '0;
          w_cpu_reset_d  = 1'b1;
        end
      end
      StLenHi: begin
        if (w_accept) begin
          w_len_hi_d = i_rx_data;
          w_state_d  = StLenLo;
        end
      end
      StLenLo: begin
        if (w_accept) begin
          w_len_d = w_len_rx;
          if (32'(w_len_rx) > DEPTH) begin
            w_state_d = StError;
            w_error_d = ERR_LEN;
          end else if (w_len_rx == 16'd0) begin
            w_state_d = StCheck;
          end else begin
            w_state_d = StDataHi;
          end
        end
      end
      StDataHi: begin
        if (w_accept) begin
          w_data_hi_d = i_rx_data;
          w_xor_d     = r_xor ^ i_rx_data;
          w_state_d   = StDataLo;
        end
      end
      StDataLo: begin
        if (w_accept) begin
          w_xor_d        = r_xor ^ i_rx_data;
          w_imem_we_d    = 1'b1;
          w_imem_addr_d  = r_word_count[ADDR_W-1:0];
          w_imem_wdata_d = {r_data_hi, i_rx_data};
          w_word_count_d = w_wc_inc;
          w_state_d      = (32'(w_wc_inc) < 32'(r_len)) ? StDataHi : StCheck;
        end
      end
      StCheck: begin
        if (w_accept) begin
          if (i_rx_data == r_xor) begin
            w_state_d     = StDone;
            w_done_d      = 1'b1;
            w_cpu_reset_d = 1'b0;
          end else begin
            w_state_d = StError;
            w_error_d = ERR_CSUM;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase

    // A byte arriving on the expiry cycle wins over the timeout.
    if (w_expired && !w_accept) begin
      w_state_d = StError;
      w_error_d = ERR_TIMEOUT;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= StIdle;
      r_rx_ready   <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_cpu_reset  <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= ERR_NONE;
      r_word_count <= '0;
      r_len_hi     <= '0;
      r_len        <= '0;
      r_data_hi    <= '0;
      r_xor        <= '0;
    end else begin
      r_state      <= w_state_d;
      r_rx_ready   <= state_ready(w_state_d);
      r_imem_we    <= w_imem_we_d;
      r_imem_addr  <= w_imem_addr_d;
      r_imem_wdata <= w_imem_wdata_d;
      r_cpu_reset  <= w_cpu_reset_d;
      r_done       <= w_done_d;
      r_error      <= w_error_d;
      r_word_count <= w_word_count_d;
      r_len_hi     <= w_len_hi_d;
      r_len        <= w_len_d;
      r_data_hi    <= w_data_hi_d;
      r_xor        <= w_xor_d;
    end
  end

  assign o_rx_ready   = r_rx_ready;
  assign o_imem_we    = r_imem_we;
  assign o_imem_addr  = r_imem_addr;
  assign o_imem_wdata = r_imem_wdata;
  assign o_cpu_reset  = r_cpu_reset;
  assign o_done       = r_done;
  assign o_error      = r_error;
  assign o_word_count = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with hand-computed expectations.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready;
  logic        o_imem_we;
  logic [14:0] o_imem_addr;
  logic [15:0] o_imem_wdata;
  logic        o_cpu_reset;
  logic        o_done;
  logic [1:0]  o_error;
  logic [15:0] o_word_count;

  int n_cmp = 0;
  int n_err = 0;
  int wr_n  = 0;
  int base;
  int gap_max = 0;
  logic [14:0] wr_addr [8];
  logic [15:0] wr_data [8];

  always #5 clk = ~clk;

  imem_loader #(
    .ADDR_W  (15),
    .DEPTH   (4096),
    .TIMEOUT (50),
    .TO_W    (20)
  ) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_rx_ready   (o_rx_ready),
    .o_imem_we    (o_imem_we),
    .o_imem_addr  (o_imem_addr),
    .o_imem_wdata (o_imem_wdata),
    .o_cpu_reset  (o_cpu_reset),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_word_count (o_word_count)
  );

  // Log every RAM write strobe.
  always @(negedge clk) begin
    if (o_imem_we) begin
      if (wr_n < 8) begin
        wr_addr[wr_n] = o_imem_addr;
        wr_data[wr_n] = o_imem_wdata;
      end
      wr_n = wr_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  // Offer one byte and hold it until accepted; returns 1 ns after the accept edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    if (gap_max > 0) begin
      repeat ($urandom_range(0, gap_max)) step();
    end
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    n = 0;
    while (!o_rx_ready && n < 200) begin
      step();
      n = n + 1;
    end
    if (!o_rx_ready) check("rx_ready_wait", 32'(o_rx_ready), 32'd1);
    step();
    i_rx_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    i_reset    = 1'b0;
    i_start    = 1'b0;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;
    repeat (2) step();
    check("rst_rx_ready", 32'(o_rx_ready), 32'd0);
    check("rst_we", 32'(o_imem_we), 32'd0);
    check("rst_addr", 32'(o_imem_addr), 32'd0);
    check("rst_wdata", 32'(o_imem_wdata), 32'd0);
    check("rst_cpu_reset", 32'(o_cpu_reset), 32'd1);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_error", 32'(o_error), 32'd0);
    check("rst_wc", 32'(o_word_count), 32'd0);
    i_reset = 1'b1;
    step();

    // Add program: two words; checksum = 00^02^EC^10 = FE.
    base = wr_n;
    pulse_start();
    check("add_ready_after_start", 32'(o_rx_ready), 32'd1);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h02);
    check("add_we0", 32'(o_imem_we), 32'd1);
    check("add_addr0", 32'(o_imem_addr), 32'd0);
    check("add_wdata0", 32'(o_imem_wdata), 32'h0002);
    check("add_wc1", 32'(o_word_count), 32'd1);
    send_byte(8'hEC);
    check("add_we_gap", 32'(o_imem_we), 32'd0);
    send_byte(8'h10);
    check("add_we1", 32'(o_imem_we), 32'd1);
    check("add_addr1", 32'(o_imem_addr), 32'd1);
    check("add_wdata1", 32'(o_imem_wdata), 32'hEC10);
    check("add_cpu_reset_pre", 32'(o_cpu_reset), 32'd1);
    send_byte(8'hFE);
    check("add_done", 32'(o_done), 32'd1);
    check("add_cpu_reset", 32'(o_cpu_reset), 32'd0);
    check("add_error", 32'(o_error), 32'd0);
    check("add_wc", 32'(o_word_count), 32'd2);
    check("add_rx_ready", 32'(o_rx_ready), 32'd0);
    step();
    check("add_writes", 32'(wr_n - base), 32'd2);
    check("add_log_a0", 32'(wr_addr[0]), 32'd0);
    check("add_log_d1", 32'(wr_data[1]), 32'hEC10);

    // Same frame, wrong checksum.
    pulse_start();
    check("csum_done_cleared", 32'(o_done), 32'd0);
    check("csum_cpu_reset_set", 32'(o_cpu_reset), 32'd1);
    check("csum_wc_cleared", 32'(o_word_count), 32'd0);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'hEC);
    send_byte(8'h10);
    send_byte(8'h00);
    check("csum_error", 32'(o_error), 32'd2);
    check("csum_done", 32'(o_done), 32'd0);
    check("csum_cpu_reset", 32'(o_cpu_reset), 32'd1);
    check("csum_wc", 32'(o_word_count), 32'd2);

    // Length 4097 exceeds DEPTH.
    base = wr_n;
    pulse_start();
    check("len_error_cleared", 32'(o_error), 32'd0);
    send_byte(8'h10);
    send_byte(8'h01);
    check("len_error", 32'(o_error), 32'd1);
    check("len_rx_ready", 32'(o_rx_ready), 32'd0);
    repeat (3) step();
    check("len_no_writes", 32'(wr_n - base), 32'd0);
    check("len_cpu_reset", 32'(o_cpu_reset), 32'd1);

    // Length 4096 is the largest legal length: no error after the length bytes.
    pulse_start();
    send_byte(8'h10);
    send_byte(8'h00);
    check("len_max_ok", 32'(o_error), 32'd0);
    check("len_max_ready", 32'(o_rx_ready), 32'd1);
    i_reset = 1'b0;
    step();
    i_reset = 1'b1;

    // Empty program.
    base = wr_n;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    check("zero_done", 32'(o_done), 32'd1);
    check("zero_cpu_reset", 32'(o_cpu_reset), 32'd0);
    check("zero_wc", 32'(o_word_count), 32'd0);
    check("zero_writes", 32'(wr_n - base), 32'd0);
    pulse_start();
    check("restart_cpu_reset", 32'(o_cpu_reset), 32'd1);
    check("restart_done", 32'(o_done), 32'd0);

    // Stall after the first data byte: error lands on the 50th idle edge.
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAB);
    repeat (49) step();
    check("to_early", 32'(o_error), 32'd0);
    step();
    check("to_fire", 32'(o_error), 32'd3);
    check("to_rx_ready", 32'(o_rx_ready), 32'd0);
    check("to_cpu_reset", 32'(o_cpu_reset), 32'd1);

    // Gappy stream, start ignored mid-load, then reset while in DATA_LO.
    gap_max = 3;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h12);
    send_byte(8'h34);
    step();
    check("mid_wc", 32'(o_word_count), 32'd1);
    pulse_start();
    check("mid_start_ignored_wc", 32'(o_word_count), 32'd1);
    check("mid_start_ignored_err", 32'(o_error), 32'd0);
    send_byte(8'h56);
    check("mid_in_data_lo", 32'(o_rx_ready), 32'd1);
    i_rx_data  = 8'h78;
    i_rx_valid = 1'b1;
    i_reset    = 1'b0;
    step();
    i_reset    = 1'b1;
    i_rx_valid = 1'b0;
    check("mid_rst_rx_ready", 32'(o_rx_ready), 32'd0);
    check("mid_rst_we", 32'(o_imem_we), 32'd0);
    check("mid_rst_addr", 32'(o_imem_addr), 32'd0);
    check("mid_rst_wdata", 32'(o_imem_wdata), 32'd0);
    check("mid_rst_cpu_reset", 32'(o_cpu_reset), 32'd1);
    check("mid_rst_done", 32'(o_done), 32'd0);
    check("mid_rst_error", 32'(o_error), 32'd0);
    check("mid_rst_wc", 32'(o_word_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
